alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Downstream neighbour of the ALU: captures the 64-bit ALU result Z and serialises it onto the 32-bit datapath bus.
- Delivers LO, then HI for wide ops (MUL/DIV); delivers LO only for all other ops.
- Updates the architectural HI/LO registers on wide ops.
- Replaces the bare Z register. Provides a valid/ready handshake on both sides so a multi-cycle divider can plug in later.

Parameters:
- WIDTH, 32, datapath word width; Z is 2*WIDTH.
- OPP_W, 16, width of the one-hot ALU op vector.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- alu_z  in  2*WIDTH  ALU result Z
- alu_opp  in  OPP_W  one-hot ALU op that produced alu_z (bit indices from the shared package)
- z_valid  in  1  alu_z/alu_opp valid this cycle
- z_ready  out  1  stage can accept a result this cycle
- bus_data  out  WIDTH  word driven to the bus
- bus_valid  out  1  bus_data valid
- bus_is_hi  out  1  1 = bus_data is Z[2W-1:W], 0 = Z[W-1:0]
- bus_ready  in  1  bus consumer takes the word this cycle
- hi_q  out  WIDTH  HI register
- lo_q  out  WIDTH  LO register

Behaviour:
- Reset (clear_n=0, asynchronous, any state):
  - State goes to IDLE.
  - z_q, hi_q, lo_q, bus_data, bus_valid, bus_is_hi and wide_q all go to 0.
  - An in-flight result is dropped.
  - z_ready is 1 while in IDLE after reset.
- States:
  - IDLE: bus_valid=0.
  - DRIVE_LO: bus_valid=1, bus_data=z_q[W-1:0], bus_is_hi=0.
  - DRIVE_HI: bus_valid=1, bus_data=z_q[2W-1:W], bus_is_hi=1.
- Outputs bus_valid, bus_data and bus_is_hi are decoded from registered state and z_q only; none are combinational from inputs.
- Wide op: wide = alu_opp[MUL] | alu_opp[DIV]. Evaluated at capture and held in wide_q. alu_opp=0 or any other bit pattern counts as narrow.
- Last beat:
  - DRIVE_LO is last when wide_q=0.
  - DRIVE_HI is always last.
- z_ready = (state==IDLE) | (last_beat & bus_ready). This is combinational, so a back-to-back capture costs zero bubble cycles.
- Capture (z_valid & z_ready):
  - z_q <= alu_z; wide_q <= wide; next state DRIVE_LO.
  - If wide: hi_q <= alu_z[2W-1:W] and lo_q <= alu_z[W-1:0] at the same edge.
- Transitions:
  - DRIVE_LO with bus_ready: wide_q → DRIVE_HI; otherwise → IDLE, or → DRIVE_LO with new data if a capture happens in the same cycle.
  - DRIVE_HI with bus_ready: → IDLE, or → DRIVE_LO if a capture happens in the same cycle.
  - No bus_ready: hold state, hold bus_data stable, keep bus_valid=1.
- z_valid while z_ready=0 is ignored. The upstream stage must hold its data until it sees ready.
- Latency: capture edge → bus_valid=1 on the next cycle.
  - Narrow op: 1 beat.
  - Wide op: 2 beats, LO first.
- DIV packing contract: quotient in Z[W-1:0], remainder in Z[2W-1:W]. So lo_q = quotient and hi_q = remainder.
- hi_q/lo_q are untouched by narrow ops and persist until the next wide capture or reset.

Optional Feature:
- Macro: ALU_RESULT_FLAGS_EN.
- When defined:
  - Extra outputs z_zero and z_neg (1 bit each), registered at capture.
  - z_zero = (alu_z[W-1:0]==0) for narrow ops; (alu_z==0) for wide ops.
  - z_neg = alu_z[W-1] for narrow ops; alu_z[2W-1] for wide ops.
  - Both reset to 0 and hold until the next capture.
- When undefined: the ports are absent and there is no flag logic.

Decomposition:
- Package alu_pkg holds:
  - ALU op bit-index constants: ADD=0, SUB=1, NEG=2, MUL=3, DIV=4, AND=5, OR=6, ROR=7, ROL=8, SLL=9, SRA=10, SRL=11, NOT=12, INC=13. These replace the per-file defines.
  - Enum typedef res_state_t {IDLE, DRIVE_LO, DRIVE_HI}.
- Sub-module: hi_lo_regfile (HI/LO pair with async clear_n and a single write enable). Reused later by mfhi/mflo.

Test Plan:
- Reset mid-DRIVE_HI (capture MUL Z=64'h0000_0001_0000_0002, one LO beat taken, then pulse clear_n low) → IDLE, bus_valid=0, hi_q=lo_q=0, z_ready=1.
- ADD result Z=15, bus_ready=1 → one beat bus_data=15, bus_is_hi=0; hi_q/lo_q unchanged (0).
- MUL Z=64'h0000_0002_8000_0000 with bus_ready=0 for 3 cycles, then 1 → LO beat 32'h8000_0000 held stable for 4 cycles, then HI beat 32'h2; hi_q=2, lo_q=32'h8000_0000 from the capture edge.
- Back-to-back: SUB Z=10, then AND Z=32'h0 presented with z_valid held high and bus_ready=1 → beats 10, 0 on consecutive cycles with no bubble; z_ready=1 in the last-beat cycle.
- DIV 20/6 packed Z={32'd2, 32'd3} → beats 3, then 2; lo_q=3, hi_q=2. A z_valid pulse during the HI beat with bus_ready=0 is ignored.
- ALU_RESULT_FLAGS_EN defined: NEG of 7 (Z low word 32'hFFFF_FFF9) → z_neg=1, z_zero=0. Then ADD Z=0 → z_zero=1, z_neg=0.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: one-hot op bit positions and the result-stage state encoding.
package alu_pkg;

    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int NEG = 2;
    localparam int MUL = 3;
    localparam int DIV = 4;
    localparam int AND = 5;
    localparam int OR  = 6;
    localparam int ROR = 7;
    localparam int ROL = 8;
    localparam int SLL = 9;
    localparam int SRA = 10;
    localparam int SRL = 11;
    localparam int NOT = 12;
    localparam int INC = 13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE_LO = 2'd1,
        DRIVE_HI = 2'd2
    } res_state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Result-stage signal bundle: ALU-side capture handshake, bus-side beat handshake, HI/LO view.
// slave = the result stage itself, master = its surroundings. Flags exist only with ALU_RESULT_FLAGS_EN.
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int OPP_W = 16
);
    logic [2*WIDTH-1:0] alu_z;
    logic [OPP_W-1:0]   alu_opp;
    logic               z_valid;
    logic               z_ready;
    logic [WIDTH-1:0]   bus_data;
    logic               bus_valid;
    logic               bus_is_hi;
    logic               bus_ready;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
`ifdef ALU_RESULT_FLAGS_EN
    logic               z_zero;
    logic               z_neg;
`endif

    modport slave (
`ifdef ALU_RESULT_FLAGS_EN
        output z_zero, output z_neg,
`endif
        input  alu_z, input alu_opp, input z_valid, output z_ready,
        output bus_data, output bus_valid, output bus_is_hi, input bus_ready,
        output hi_q, output lo_q
    );

    modport master (
`ifdef ALU_RESULT_FLAGS_EN
        input  z_zero, input z_neg,
`endif
        output alu_z, output alu_opp, output z_valid, input z_ready,
        input  bus_data, input bus_valid, input bus_is_hi, output bus_ready,
        input  hi_q, input lo_q
    );

endinterface

// File: rtl/alu_result_stage_hi_lo_regfile.sv
// HI/LO architectural register pair, both words written together on a single enable.
// Latency: written value visible the cycle after the enable edge. No backpressure.
module hi_lo_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             we,
    input  logic [WIDTH-1:0] hi_d,
    input  logic [WIDTH-1:0] lo_d,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Captures 64-bit ALU result and serialises it to the 32-bit bus (LO, then HI for MUL/DIV); ALU_RESULT_FLAGS_EN adds zero/neg flags.
// Latency: first beat valid the cycle after capture. Backpressure: bus_ready low holds the beat; z_ready drops until the last beat leaves.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPP_W = 16
) (
    input  logic               clock,
    input  logic               clear_n,
    alu_result_stage_if.slave  rs
);

    res_state_t          state_q, state_d;
    logic [2*WIDTH-1:0]  z_q;
    logic                wide_q;
    logic [OPP_W-1:0]    opp;
    logic                wide;
    logic                last_beat;
    logic                capture;

    assign opp  = rs.alu_opp;
    assign wide = opp[MUL] | opp[DIV];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rs.bus_valid = 1'b0;
        rs.bus_data  = '0;
        rs.bus_is_hi = 1'b0;
        last_beat    = 1'b0;

        case (state_q)
            DRIVE_LO: begin
                rs.bus_valid = 1'b1;
                rs.bus_data  = z_q[WIDTH-1:0];
                last_beat    = !wide_q;
            end
            DRIVE_HI: begin
                rs.bus_valid = 1'b1;
                rs.bus_data  = z_q[2*WIDTH-1:WIDTH];
                rs.bus_is_hi = 1'b1;
                last_beat    = 1'b1;
            end
            default: ;
        endcase

        // Ready in the last-beat cycle lets a new result follow with no bubble.
        rs.z_ready = (state_q == IDLE) | (last_beat & rs.bus_ready);
        capture    = rs.z_valid & rs.z_ready;

        case (state_q)
            IDLE: begin
                if (capture) state_d = DRIVE_LO;
            end
            DRIVE_LO: begin
                if (rs.bus_ready) begin
                    if (wide_q)       state_d = DRIVE_HI;
                    else if (capture) state_d = DRIVE_LO;
                    else              state_d = IDLE;
                end
            end
            DRIVE_HI: begin
                if (rs.bus_ready) state_d = capture ? DRIVE_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            z_q    <= '0;
            wide_q <= 1'b0;
        end else if (capture) begin
            z_q    <= rs.alu_z;
            wide_q <= wide;
        end
    end

    // DIV packs quotient low / remainder high, so lo_q = quotient, hi_q = remainder.
    hi_lo_regfile #(.WIDTH(WIDTH)) u_hi_lo (
        .clock   (clock),
        .clear_n (clear_n),
        .we      (capture & wide),
        .hi_d    (rs.alu_z[2*WIDTH-1:WIDTH]),
        .lo_d    (rs.alu_z[WIDTH-1:0]),
        .hi_q    (rs.hi_q),
        .lo_q    (rs.lo_q)
    );

`ifdef ALU_RESULT_FLAGS_EN
    logic z_zero_q, z_neg_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            z_zero_q <= 1'b0;
            z_neg_q  <= 1'b0;
        end else if (capture) begin
            z_zero_q <= wide ? (rs.alu_z == '0) : (rs.alu_z[WIDTH-1:0] == '0);
            z_neg_q  <= wide ? rs.alu_z[2*WIDTH-1] : rs.alu_z[WIDTH-1];
        end
    end

    assign rs.z_zero = z_zero_q;
    assign rs.z_neg  = z_neg_q;
`endif

endmodule
